// File: rtl/scratch_pad_port_arbiter_if.sv
// Client and port side signals of the scratch pad port arbiter.
// The arbiter connects through the slave modport. The environment
// (client engines plus the scratch pad port) drives through master.
interface scratch_pad_port_arbiter_if #(
    parameter int REQUESTERS = 4,
    parameter int WIDTH      = 64,
    parameter int ADDR_WIDTH = 12
);
    logic [REQUESTERS-1:0]            req_rd_en;
    logic [REQUESTERS-1:0]            req_wr_en;
    logic [REQUESTERS*ADDR_WIDTH-1:0] req_addr;
    logic [REQUESTERS*WIDTH-1:0]      req_d;
    logic [REQUESTERS-1:0]            req_grant;

    logic                             sp_rd_en;
    logic                             sp_wr_en;
    logic [ADDR_WIDTH-1:0]            sp_addr;
    logic [WIDTH-1:0]                 sp_d;
    logic                             sp_full;
    logic                             sp_valid;
    logic [WIDTH-1:0]                 sp_q;
    logic                             sp_stall;

    logic [REQUESTERS-1:0]            rsp_valid;
    logic [WIDTH-1:0]                 rsp_q;
    logic [REQUESTERS-1:0]            rsp_stall;

    logic                             err;

    modport slave (
        input  req_rd_en, req_wr_en, req_addr, req_d,
        input  sp_full, sp_valid, sp_q, rsp_stall,
        output req_grant, sp_rd_en, sp_wr_en, sp_addr, sp_d,
        output sp_stall, rsp_valid, rsp_q, err
    );

    modport master (
        output req_rd_en, req_wr_en, req_addr, req_d,
        output sp_full, sp_valid, sp_q, rsp_stall,
        input  req_grant, sp_rd_en, sp_wr_en, sp_addr, sp_d,
        input  sp_stall, rsp_valid, rsp_q, err
    );
endinterface

// File: rtl/scratch_pad_port_arbiter.sv
// Round-robin arbiter sharing one scratch pad port among several clients.
// Granted commands are registered onto the port. Read IDs are kept in an
// in-order FIFO so returning data can be steered back to the issuer.
module scratch_pad_port_arbiter #(
    parameter int REQUESTERS      = 4,
    parameter int WIDTH           = 64,
    parameter int ADDR_WIDTH      = 12,
    parameter int MAX_OUTSTANDING = 32,
    parameter int ID_BITS         = $clog2(REQUESTERS)
) (
    input  logic                          clk,
    input  logic                          rst,
    scratch_pad_port_arbiter_if.slave     bus
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    logic [ID_BITS-1:0]    last_grant;
    logic [ID_BITS-1:0]    gnt_idx;
    logic                  gnt_any;
    logic                  gnt_is_wr;
    logic [REQUESTERS-1:0] gnt_oh;
    logic [REQUESTERS-1:0] eligible;
    logic                  rd_ok;

    logic [ID_BITS-1:0]    id_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [ID_BITS-1:0]    head_id;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;

    logic                  sp_rd_en_r;
    logic                  sp_wr_en_r;
    logic [ADDR_WIDTH-1:0] sp_addr_r;
    logic [WIDTH-1:0]      sp_d_r;
    logic                  err_r;
    logic [REQUESTERS-1:0] rsp_valid_c;
    logic                  sp_stall_c;

    // Eligibility: nothing while the port is full; reads also need a free ID slot.
    always_comb begin
        rd_ok = count < CNT_W'(MAX_OUTSTANDING);
        for (int i = 0; i < REQUESTERS; i++) begin
            eligible[i] = ~bus.sp_full & (bus.req_wr_en[i] | (bus.req_rd_en[i] & rd_ok));
        end
    end

    // Round-robin search starting just after the previous winner.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_oh  = '0;
        for (int k = 1; k <= REQUESTERS; k++) begin
            logic [ID_BITS-1:0] cand;
            cand = ID_BITS'((int'(last_grant) + k) % REQUESTERS);
            if (!gnt_any && eligible[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_any) gnt_oh[gnt_idx] = 1'b1;
    end

    // A request with both enables set goes out as a write; its read half is dropped.
    assign gnt_is_wr  = bus.req_wr_en[gnt_idx];
    assign push       = gnt_any & ~gnt_is_wr;
    assign head_id    = id_mem[rd_ptr];
    assign fifo_empty = (count == '0);

    // Steer returning data to the head ID; data with no outstanding read is dropped.
    always_comb begin
        rsp_valid_c = '0;
        sp_stall_c  = 1'b0;
        pop         = 1'b0;
        if (bus.sp_valid && !fifo_empty) begin
            rsp_valid_c[head_id] = 1'b1;
            sp_stall_c           = bus.rsp_stall[head_id];
            pop                  = ~bus.rsp_stall[head_id];
        end
    end

    // Register the granted command onto the port; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_rd_en_r <= 1'b0;
            sp_wr_en_r <= 1'b0;
            sp_addr_r  <= '0;
            sp_d_r     <= '0;
            last_grant <= ID_BITS'(REQUESTERS - 1);
        end else begin
            sp_rd_en_r <= gnt_any & ~gnt_is_wr;
            sp_wr_en_r <= gnt_any & gnt_is_wr;
            if (gnt_any) begin
                sp_addr_r  <= bus.req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                sp_d_r     <= bus.req_d[int'(gnt_idx)*WIDTH +: WIDTH];
                last_grant <= gnt_idx;
            end
        end
    end

    // ID FIFO storage; contents are don't-care while empty so no reset needed.
    always_ff @(posedge clk) begin
        if (push) id_mem[wr_ptr] <= gnt_idx;
    end

    // ID FIFO pointers and occupancy, which doubles as the outstanding-read count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky flag for read data arriving with nothing outstanding.
    always_ff @(posedge clk) begin
        if (rst)                             err_r <= 1'b0;
        else if (bus.sp_valid && fifo_empty) err_r <= 1'b1;
    end

    assign bus.req_grant = gnt_oh;
    assign bus.sp_rd_en  = sp_rd_en_r;
    assign bus.sp_wr_en  = sp_wr_en_r;
    assign bus.sp_addr   = sp_addr_r;
    assign bus.sp_d      = sp_d_r;
    assign bus.sp_stall  = sp_stall_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_q     = bus.sp_q;
    assign bus.err       = err_r;
endmodule

// File: tb/tb_scratch_pad_port_arbiter.sv
// Directed bench for scratch_pad_port_arbiter: one task per scenario.
module tb_scratch_pad_port_arbiter;
    localparam int R  = 4;
    localparam int W  = 64;
    localparam int AW = 12;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    scratch_pad_port_arbiter_if #(.REQUESTERS(R), .WIDTH(W), .ADDR_WIDTH(AW)) bus();

    scratch_pad_port_arbiter #(
        .REQUESTERS(R), .WIDTH(W), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_rd_en = '0;
        bus.req_wr_en = '0;
        bus.req_addr  = '0;
        bus.req_d     = '0;
        bus.sp_full   = 1'b0;
        bus.sp_valid  = 1'b0;
        bus.sp_q      = '0;
        bus.rsp_stall = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a, input logic [W-1:0] d);
        bus.req_addr[i*AW +: AW] = a;
        bus.req_d[i*W +: W]      = d;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests_run++; if (bus.sp_rd_en !== 1'b0) begin tests_failed++; $display("FAIL reset_sp_rd_en: got %b want 0", bus.sp_rd_en); end
        tests_run++; if (bus.sp_wr_en !== 1'b0) begin tests_failed++; $display("FAIL reset_sp_wr_en: got %b want 0", bus.sp_wr_en); end
        tests_run++; if (bus.sp_addr !== 12'h000) begin tests_failed++; $display("FAIL reset_sp_addr: got %h want 000", bus.sp_addr); end
        tests_run++; if (bus.sp_d !== 64'h0) begin tests_failed++; $display("FAIL reset_sp_d: got %h want 0", bus.sp_d); end
        tests_run++; if (bus.err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", bus.err); end
        tests_run++; if (bus.req_grant !== 4'b0000) begin tests_failed++; $display("FAIL reset_grant: got %b want 0000", bus.req_grant); end
        tests_run++; if (bus.rsp_valid !== 4'b0000 || bus.sp_stall !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp: got valid=%b stall=%b want 0000/0", bus.rsp_valid, bus.sp_stall); end
    endtask

    task automatic test_single_read();
        set_addr(2, 12'h010, 64'h0);
        bus.req_rd_en = 4'b0100;
        #1;
        tests_run++; if (bus.req_grant !== 4'b0100) begin tests_failed++; $display("FAIL single_grant: got %b want 0100", bus.req_grant); end
        tick();
        bus.req_rd_en = 4'b0000;
        #1;
        tests_run++; if (bus.sp_rd_en !== 1'b1 || bus.sp_wr_en !== 1'b0 || bus.sp_addr !== 12'h010) begin tests_failed++; $display("FAIL single_issue: got rd=%b wr=%b addr=%h want 1/0/010", bus.sp_rd_en, bus.sp_wr_en, bus.sp_addr); end
        bus.sp_valid = 1'b1;
        bus.sp_q     = 64'hAB;
        #1;
        tests_run++; if (bus.rsp_valid !== 4'b0100 || bus.rsp_q !== 64'hAB || bus.sp_stall !== 1'b0) begin tests_failed++; $display("FAIL single_rsp: got valid=%b q=%h stall=%b want 0100/ab/0", bus.rsp_valid, bus.rsp_q, bus.sp_stall); end
        tick();
        bus.sp_valid = 1'b0;
        #1;
        tests_run++; if (bus.sp_rd_en !== 1'b0 || bus.sp_addr !== 12'h010) begin tests_failed++; $display("FAIL single_idle_hold: got rd=%b addr=%h want 0/010", bus.sp_rd_en, bus.sp_addr); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        do_reset();
        for (int i = 0; i < R; i++) set_addr(i, 12'(12'h100 + i), 64'h0);
        bus.req_rd_en = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            exp = 4'b0001 << (c % 4);
            #1;
            tests_run++; if (bus.req_grant !== exp) begin tests_failed++; $display("FAIL rr_grant_%0d: got %b want %b", c, bus.req_grant, exp); end
            tick();
            if (c == 7) bus.req_rd_en = 4'b0000;
            tests_run++; if (bus.sp_rd_en !== 1'b1 || bus.sp_addr !== 12'(12'h100 + c % 4)) begin tests_failed++; $display("FAIL rr_issue_%0d: got rd=%b addr=%h want 1/%h", c, bus.sp_rd_en, bus.sp_addr, 12'(12'h100 + c % 4)); end
        end
        for (int j = 0; j < 8; j++) begin
            exp = 4'b0001 << (j % 4);
            bus.sp_valid = 1'b1;
            bus.sp_q     = 64'(64'h1000 + j);
            #1;
            tests_run++; if (bus.rsp_valid !== exp || bus.rsp_q !== 64'(64'h1000 + j)) begin tests_failed++; $display("FAIL rr_rsp_%0d: got valid=%b q=%h want %b/%h", j, bus.rsp_valid, bus.rsp_q, exp, 64'(64'h1000 + j)); end
            tick();
        end
        bus.sp_valid = 1'b0;
    endtask

    task automatic test_write_read_full();
        set_addr(0, 12'h003, 64'h55);
        set_addr(1, 12'h003, 64'h0);
        bus.req_wr_en = 4'b0001;
        bus.req_rd_en = 4'b0010;
        bus.sp_full   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests_run++; if (bus.req_grant !== 4'b0000) begin tests_failed++; $display("FAIL full_grant_%0d: got %b want 0000", c, bus.req_grant); end
            tick();
            tests_run++; if (bus.sp_rd_en !== 1'b0 || bus.sp_wr_en !== 1'b0) begin tests_failed++; $display("FAIL full_issue_%0d: got rd=%b wr=%b want 0/0", c, bus.sp_rd_en, bus.sp_wr_en); end
        end
        bus.sp_full = 1'b0;
        #1;
        tests_run++; if (bus.req_grant !== 4'b0001) begin tests_failed++; $display("FAIL mix_wr_grant: got %b want 0001", bus.req_grant); end
        tick();
        bus.req_wr_en = 4'b0000;
        #1;
        tests_run++; if (bus.sp_wr_en !== 1'b1 || bus.sp_rd_en !== 1'b0 || bus.sp_addr !== 12'h003 || bus.sp_d !== 64'h55) begin tests_failed++; $display("FAIL mix_wr_issue: got wr=%b rd=%b addr=%h d=%h want 1/0/003/55", bus.sp_wr_en, bus.sp_rd_en, bus.sp_addr, bus.sp_d); end
        tests_run++; if (bus.req_grant !== 4'b0010) begin tests_failed++; $display("FAIL mix_rd_grant: got %b want 0010", bus.req_grant); end
        tick();
        bus.req_rd_en = 4'b0000;
        #1;
        tests_run++; if (bus.sp_rd_en !== 1'b1 || bus.sp_wr_en !== 1'b0) begin tests_failed++; $display("FAIL mix_rd_issue: got rd=%b wr=%b want 1/0", bus.sp_rd_en, bus.sp_wr_en); end
        bus.sp_valid = 1'b1;
        bus.sp_q     = 64'h55;
        #1;
        tests_run++; if (bus.rsp_valid !== 4'b0010 || bus.rsp_q !== 64'h55) begin tests_failed++; $display("FAIL mix_rsp: got valid=%b q=%h want 0010/55", bus.rsp_valid, bus.rsp_q); end
        tick();
        bus.sp_valid = 1'b0;
    endtask

    task automatic test_outstanding_cap();
        int n_grants;
        int n_bad;
        do_reset();
        set_addr(0, 12'h020, 64'h0);
        set_addr(3, 12'h030, 64'h99);
        bus.req_rd_en = 4'b0001;
        n_grants = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus.req_grant[0]) n_grants++;
            tick();
        end
        tests_run++; if (n_grants !== 32) begin tests_failed++; $display("FAIL cap_read_grants: got %0d want 32", n_grants); end
        bus.req_wr_en = 4'b1000;
        #1;
        tests_run++; if (bus.req_grant !== 4'b1000) begin tests_failed++; $display("FAIL cap_write_grant: got %b want 1000", bus.req_grant); end
        tick();
        bus.req_wr_en = 4'b0000;
        #1;
        tests_run++; if (bus.req_grant !== 4'b0000) begin tests_failed++; $display("FAIL cap_still_blocked: got %b want 0000", bus.req_grant); end
        bus.sp_valid = 1'b1;
        bus.sp_q     = 64'h1;
        #1;
        tests_run++; if (bus.rsp_valid !== 4'b0001) begin tests_failed++; $display("FAIL cap_rsp: got %b want 0001", bus.rsp_valid); end
        tick();
        bus.sp_valid = 1'b0;
        #1;
        tests_run++; if (bus.req_grant !== 4'b0001) begin tests_failed++; $display("FAIL cap_freed_grant: got %b want 0001", bus.req_grant); end
        tick();
        #1;
        tests_run++; if (bus.req_grant !== 4'b0000) begin tests_failed++; $display("FAIL cap_one_only: got %b want 0000", bus.req_grant); end
        bus.req_rd_en = 4'b0000;
        n_bad = 0;
        for (int j = 0; j < 32; j++) begin
            bus.sp_valid = 1'b1;
            bus.sp_q     = 64'(j);
            #1;
            if (bus.rsp_valid !== 4'b0001 || bus.sp_stall !== 1'b0) n_bad++;
            tick();
        end
        bus.sp_valid = 1'b0;
        tests_run++; if (n_bad !== 0) begin tests_failed++; $display("FAIL cap_drain: got %0d bad responses want 0", n_bad); end
    endtask

    task automatic test_response_stall();
        set_addr(1, 12'h040, 64'h0);
        bus.req_rd_en = 4'b0010;
        #1;
        tests_run++; if (bus.req_grant !== 4'b0010) begin tests_failed++; $display("FAIL stall_grant: got %b want 0010", bus.req_grant); end
        tick();
        bus.req_rd_en = 4'b0000;
        bus.sp_valid  = 1'b1;
        bus.sp_q      = 64'h77;
        bus.rsp_stall = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            #1;
            tests_run++; if (bus.sp_stall !== 1'b1 || bus.rsp_valid !== 4'b0010) begin tests_failed++; $display("FAIL stall_hold_%0d: got stall=%b valid=%b want 1/0010", c, bus.sp_stall, bus.rsp_valid); end
            tick();
        end
        bus.rsp_stall = 4'b0000;
        #1;
        tests_run++; if (bus.sp_stall !== 1'b0 || bus.rsp_valid !== 4'b0010 || bus.rsp_q !== 64'h77) begin tests_failed++; $display("FAIL stall_release: got stall=%b valid=%b q=%h want 0/0010/77", bus.sp_stall, bus.rsp_valid, bus.rsp_q); end
        tick();
        bus.sp_valid = 1'b0;
    endtask

    task automatic test_protocol_error();
        #1;
        tests_run++; if (bus.err !== 1'b0) begin tests_failed++; $display("FAIL err_before: got %b want 0", bus.err); end
        bus.sp_valid = 1'b1;
        bus.sp_q     = 64'hDEAD;
        #1;
        tests_run++; if (bus.rsp_valid !== 4'b0000 || bus.sp_stall !== 1'b0) begin tests_failed++; $display("FAIL err_drop: got valid=%b stall=%b want 0000/0", bus.rsp_valid, bus.sp_stall); end
        tick();
        bus.sp_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests_run++; if (bus.err !== 1'b1 || bus.rsp_valid !== 4'b0000) begin tests_failed++; $display("FAIL err_sticky_%0d: got err=%b valid=%b want 1/0000", c, bus.err, bus.rsp_valid); end
            tick();
        end
        do_reset();
        #1;
        tests_run++; if (bus.err !== 1'b0) begin tests_failed++; $display("FAIL err_cleared: got %b want 0", bus.err); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_read_full();
        test_outstanding_cap();
        test_response_stall();
        test_protocol_error();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
